// File: rtl/pwm_duty_decoder_pkg.sv
// Shared PWM link definitions: duty code width and limits, decoder FSM states.
// Used by both the decoder and the generator side of the link.
package pwm_pkg;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_MIN = 8'd0;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// Signal bundle of the PWM duty decoder: raw PWM input plus decoded results.
// The driver/consumer side uses master, the decoder uses slave.
interface pwm_duty_decoder_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic              i_PWMIn;
    logic [DUTY_W-1:0] o_Duty;
    logic              o_DutyValid;
    logic [CNT_W-1:0]  o_HighCount;
    logic [CNT_W-1:0]  o_PeriodCount;
    logic              o_Static;
    logic              o_Overrun;

    modport master (
        output i_PWMIn,
        input  o_Duty, o_DutyValid, o_HighCount, o_PeriodCount, o_Static, o_Overrun
    );

    modport slave (
        input  i_PWMIn,
        output o_Duty, o_DutyValid, o_HighCount, o_PeriodCount, o_Static, o_Overrun
    );

endinterface

// File: rtl/pwm_duty_decoder_div.sv
// Sequential restoring divider producing floor(high*256/period), one quotient bit per cycle.
// Busy covers the done cycle too, so a new start is accepted 10 cycles after the previous one.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              i_Clock50MHz,
    input  logic              i_Reset_n,
    input  logic              i_Start,
    input  logic [CNT_W-1:0]  i_High,
    input  logic [CNT_W-1:0]  i_Period,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [DUTY_W-1:0] o_Quot,
    output logic [CNT_W-1:0]  o_High,
    output logic [CNT_W-1:0]  o_Period
);

    localparam int STEP_W = $clog2(DUTY_W);
    localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(DUTY_W - 1);

    logic [CNT_W-1:0]  r_Rem;
    logic [CNT_W-1:0]  r_Div;
    logic [CNT_W-1:0]  r_HighHold;
    logic [DUTY_W-1:0] r_Quot;
    logic [STEP_W-1:0] r_Step;
    logic              r_Busy;
    logic              r_Done;

    logic [CNT_W:0]    w_Shift;
    logic [CNT_W:0]    w_Diff;
    logic              w_Ge;
    logic [CNT_W-1:0]  w_RemNext;

    // rem < period always holds, so a clear borrow bit means the difference fits CNT_W bits
    assign w_Shift   = {r_Rem, 1'b0};
    assign w_Diff    = w_Shift - {1'b0, r_Div};
    assign w_Ge      = ~w_Diff[CNT_W];
    assign w_RemNext = w_Ge ? w_Diff[CNT_W-1:0] : w_Shift[CNT_W-1:0];

    always_ff @(posedge i_Clock50MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Rem      <= '0;
            r_Div      <= '0;
            r_HighHold <= '0;
            r_Quot     <= '0;
            r_Step     <= '0;
            r_Busy     <= 1'b0;
            r_Done     <= 1'b0;
        end else begin
            r_Done <= 1'b0;
            if (i_Start && !o_Busy) begin
                r_Rem      <= i_High;
                r_Div      <= i_Period;
                r_HighHold <= i_High;
                r_Quot     <= '0;
                r_Step     <= '0;
                r_Busy     <= 1'b1;
            end else if (r_Busy) begin
                r_Rem  <= w_RemNext;
                r_Quot <= {r_Quot[DUTY_W-2:0], w_Ge};
                r_Step <= r_Step + STEP_W'(1);
                if (r_Step == C_LAST_STEP) begin
                    r_Busy <= 1'b0;
                    r_Done <= 1'b1;
                end
            end
        end
    end

    assign o_Busy   = r_Busy | r_Done;
    assign o_Done   = r_Done;
    assign o_Quot   = r_Quot;
    assign o_High   = r_HighHold;
    assign o_Period = r_Div;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM receive end: synchronises the PWM pin, measures high time and rise-to-rise period,
// and publishes duty = floor(high*256/period), or a static 0/255 code when the line stops toggling.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              i_Clock50MHz,
    input  logic              i_Reset_n,
    pwm_duty_decoder_if.slave io_Pwm
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic r_Sync1, r_Sync2, r_SyncD;
    logic w_Rise, w_Fall;

    state_t r_State, w_StateNext;
    logic   w_Restart, w_Capture, w_Drop, w_Timeout;

    logic [CNT_W-1:0] r_Period, r_High, r_IdleCnt;

    logic              w_DivBusy, w_DivDone;
    logic [DUTY_W-1:0] w_DivQuot;
    logic [CNT_W-1:0]  w_DivHigh, w_DivPeriod;

    logic [DUTY_W-1:0] r_Duty;
    logic [CNT_W-1:0]  r_HighCount, r_PeriodCount;
    logic              r_DutyValid, r_Static, r_Overrun, r_StaticPend;

    always_ff @(posedge i_Clock50MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Sync1 <= 1'b0;
            r_Sync2 <= 1'b0;
            r_SyncD <= 1'b0;
        end else begin
            r_Sync1 <= io_Pwm.i_PWMIn;
            r_Sync2 <= r_Sync1;
            r_SyncD <= r_Sync2;
        end
    end

    assign w_Rise = r_Sync2 & ~r_SyncD;
    assign w_Fall = ~r_Sync2 & r_SyncD;

    always_ff @(posedge i_Clock50MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) r_State <= S_IDLE;
        else            r_State <= w_StateNext;
    end

    always_comb begin
        w_StateNext = r_State;
        w_Restart   = 1'b0;
        w_Capture   = 1'b0;
        w_Drop      = 1'b0;
        w_Timeout   = 1'b0;
        case (r_State)
            S_IDLE: begin
                if (w_Rise) begin
                    w_Restart   = 1'b1;
                    w_StateNext = S_HIGH;
                end else if (r_IdleCnt >= C_TIMEOUT) begin
                    w_Timeout = 1'b1;
                end
            end
            S_HIGH: begin
                if (w_Fall) begin
                    w_StateNext = S_LOW;
                end else if (r_Period >= C_TIMEOUT) begin
                    w_Timeout   = 1'b1;
                    w_StateNext = S_IDLE;
                end
            end
            S_LOW: begin
                if (w_Rise) begin
                    w_Restart   = 1'b1;
                    w_Capture   = ~w_DivBusy;
                    w_Drop      = w_DivBusy;
                    w_StateNext = S_HIGH;
                end else if (r_Period >= C_TIMEOUT) begin
                    w_Timeout   = 1'b1;
                    w_StateNext = S_IDLE;
                end
            end
            default: w_StateNext = S_IDLE;
        endcase
    end

    // The edge cycle itself counts as the first cycle of both high time and period
    always_ff @(posedge i_Clock50MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Period  <= '0;
            r_High    <= '0;
            r_IdleCnt <= '0;
        end else begin
            if (w_Restart) begin
                r_Period <= C_ONE;
                r_High   <= C_ONE;
            end else begin
                if (r_State != S_IDLE && r_Period != C_CNT_MAX) r_Period <= r_Period + C_ONE;
                if (r_State == S_HIGH && r_Sync2 && r_High != C_CNT_MAX) r_High <= r_High + C_ONE;
            end
            if (w_Timeout)                                        r_IdleCnt <= C_ONE;
            else if (r_State == S_IDLE && r_IdleCnt != C_CNT_MAX) r_IdleCnt <= r_IdleCnt + C_ONE;
        end
    end

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .i_Clock50MHz (i_Clock50MHz),
        .i_Reset_n    (i_Reset_n),
        .i_Start      (w_Capture),
        .i_High       (r_High),
        .i_Period     (r_Period),
        .o_Busy       (w_DivBusy),
        .o_Done       (w_DivDone),
        .o_Quot       (w_DivQuot),
        .o_High       (w_DivHigh),
        .o_Period     (w_DivPeriod)
    );

    // A divider result wins the publish slot; a coincident timeout is held one cycle
    always_ff @(posedge i_Clock50MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Duty        <= '0;
            r_HighCount   <= '0;
            r_PeriodCount <= '0;
            r_DutyValid   <= 1'b0;
            r_Static      <= 1'b0;
            r_Overrun     <= 1'b0;
            r_StaticPend  <= 1'b0;
        end else begin
            r_DutyValid <= 1'b0;
            r_Overrun   <= w_Drop;
            if (w_DivDone) begin
                r_Duty        <= w_DivQuot;
                r_HighCount   <= w_DivHigh;
                r_PeriodCount <= w_DivPeriod;
                r_Static      <= 1'b0;
                r_DutyValid   <= 1'b1;
                r_StaticPend  <= w_Timeout | r_StaticPend;
            end else begin
                r_StaticPend <= 1'b0;
                if (w_Timeout || r_StaticPend) begin
                    r_Duty        <= r_Sync2 ? DUTY_MAX : DUTY_MIN;
                    r_HighCount   <= r_Sync2 ? C_TIMEOUT : '0;
                    r_PeriodCount <= C_TIMEOUT;
                    r_Static      <= 1'b1;
                    r_DutyValid   <= 1'b1;
                end
            end
        end
    end

    assign io_Pwm.o_Duty        = r_Duty;
    assign io_Pwm.o_DutyValid   = r_DutyValid;
    assign io_Pwm.o_HighCount   = r_HighCount;
    assign io_Pwm.o_PeriodCount = r_PeriodCount;
    assign io_Pwm.o_Static      = r_Static;
    assign io_Pwm.o_Overrun     = r_Overrun;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: drives PWM periods, predicts each published update from the
// duty formula and the 10-cycle divider acceptance rule, and checks them in order.
module tb_pwm_duty_decoder;
    import pwm_pkg::*;

    localparam int CNT_W     = 16;
    localparam int TO        = 1200;
    localparam int CYC_LIMIT = 80000;

    typedef struct {
        logic [7:0]  duty;
        logic [15:0] high;
        logic [15:0] period;
        logic        stat;
    } rec_t;

    typedef struct {
        int         h;
        int         p;
        logic [7:0] d;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pwm_duty_decoder_if #(.CNT_W(CNT_W)) u_if ();

    pwm_duty_decoder #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .i_Clock50MHz (clk),
        .i_Reset_n    (rst_n),
        .io_Pwm       (u_if)
    );

    always #10 clk = ~clk;

    rec_t       exp_q[$];
    rec_t       mon_e;
    int         tests       = 0;
    int         failures    = 0;
    int         cyc         = 0;
    int         ovr_seen    = 0;
    int         ovr_exp     = 0;
    int         upd_idx     = 0;
    bit         meas_active = 1'b0;
    int         last_acc    = -1000;
    int         prev_h      = 0;
    int         prev_p      = 0;
    logic [7:0] prev_d      = 8'd0;
    vec_t       tv[12];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.o_Overrun === 1'b1) ovr_seen++;
            if (u_if.o_DutyValid === 1'b1) begin
                tests++;
                upd_idx++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_update_%0d: got duty=%0d high=%0d period=%0d static=%0b, required no update",
                             upd_idx, u_if.o_Duty, u_if.o_HighCount, u_if.o_PeriodCount, u_if.o_Static);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (u_if.o_Duty !== mon_e.duty || u_if.o_HighCount !== mon_e.high ||
                        u_if.o_PeriodCount !== mon_e.period || u_if.o_Static !== mon_e.stat) begin
                        failures++;
                        $display("FAIL update_%0d: got duty=%0d high=%0d period=%0d static=%0b, required duty=%0d high=%0d period=%0d static=%0b",
                                 upd_idx, u_if.o_Duty, u_if.o_HighCount, u_if.o_PeriodCount, u_if.o_Static,
                                 mon_e.duty, mon_e.high, mon_e.period, mon_e.stat);
                    end
                end
            end
        end
    end

    initial begin
        #(CYC_LIMIT * 20);
        $display("FAIL watchdog: simulation exceeded %0d cycles", CYC_LIMIT);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] duty_of(int h, int p);
        return 8'((h * 256) / p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A rise closes the period in progress; it is decoded only if the previous accepted
    // capture is at least 10 cycles old, otherwise it is reported as an overrun.
    task automatic do_rise();
        rec_t r;
        if (meas_active) begin
            if (cyc - last_acc >= 10) begin
                r.duty   = prev_d;
                r.high   = 16'(prev_h);
                r.period = 16'(prev_p);
                r.stat   = 1'b0;
                exp_q.push_back(r);
                last_acc = cyc;
            end else begin
                ovr_exp++;
            end
        end
        u_if.i_PWMIn = 1'b1;
    endtask

    task automatic drive_period(input int h, input int p, input logic [7:0] d);
        do_rise();
        meas_active = 1'b1;
        prev_h = h;
        prev_p = p;
        prev_d = d;
        repeat (h) tick();
        u_if.i_PWMIn = 1'b0;
        repeat (p - h) tick();
    endtask

    task automatic stuck(input bit level, input int k);
        rec_t r;
        do_rise();
        meas_active = 1'b0;
        for (int i = 0; i < k; i++) begin
            r.duty   = level ? 8'd255 : 8'd0;
            r.high   = level ? 16'(TO) : 16'd0;
            r.period = 16'(TO);
            r.stat   = 1'b1;
            exp_q.push_back(r);
        end
        if (level) begin
            repeat (k * TO + TO / 2) tick();
            u_if.i_PWMIn = 1'b0;
            repeat (30) tick();
        end else begin
            repeat (5) tick();
            u_if.i_PWMIn = 1'b0;
            repeat (k * TO + TO / 2 - 5) tick();
        end
    endtask

    task automatic check_section(input string name);
        drive_period(10, 40, 8'd64);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d updates still pending, required 0", name, exp_q.size());
        end
        tests++;
        if (ovr_seen != ovr_exp) begin
            failures++;
            $display("FAIL %s_overrun: got %0d overrun pulses, required %0d", name, ovr_seen, ovr_exp);
        end
        $display("[TB] section %s done at cycle %0d, updates so far %0d", name, cyc, upd_idx);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (u_if.o_Duty !== 8'd0 || u_if.o_DutyValid !== 1'b0 || u_if.o_HighCount !== 16'd0 ||
            u_if.o_PeriodCount !== 16'd0 || u_if.o_Static !== 1'b0 || u_if.o_Overrun !== 1'b0) begin
            failures++;
            $display("FAIL %s: got duty=%0d valid=%0b high=%0d period=%0d static=%0b overrun=%0b, required all 0",
                     name, u_if.o_Duty, u_if.o_DutyValid, u_if.o_HighCount, u_if.o_PeriodCount,
                     u_if.o_Static, u_if.o_Overrun);
        end
    endtask

    initial begin
        int h;
        int p;

        tv[0]  = '{128, 256, 8'd128};
        tv[1]  = '{128, 256, 8'd128};
        tv[2]  = '{128, 256, 8'd128};
        tv[3]  = '{1,   256, 8'd1};
        tv[4]  = '{2,   256, 8'd2};
        tv[5]  = '{127, 256, 8'd127};
        tv[6]  = '{254, 256, 8'd254};
        tv[7]  = '{255, 256, 8'd255};
        tv[8]  = '{250, 1000, 8'd64};
        tv[9]  = '{100, 300, 8'd85};
        tv[10] = '{3,   10,  8'd76};
        tv[11] = '{5,   17,  8'd75};

        u_if.i_PWMIn = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_zero("reset_state");
        rst_n = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 12; i++) drive_period(tv[i].h, tv[i].p, tv[i].d);
        check_section("table");

        for (int i = 0; i < 25; i++) begin
            p = int'($urandom_range(600, 10));
            h = int'($urandom_range(p - 1, 1));
            drive_period(h, p, duty_of(h, p));
        end
        check_section("random_long");

        for (int i = 0; i < 8; i++) drive_period(3, 6, 8'd128);
        check_section("overrun_p6");

        for (int i = 0; i < 30; i++) begin
            p = int'($urandom_range(14, 4));
            h = int'($urandom_range(p - 1, 1));
            drive_period(h, p, duty_of(h, p));
        end
        check_section("random_short");

        drive_period(64, 256, 8'd64);
        stuck(1'b0, 2);
        stuck(1'b1, 2);
        drive_period(200, 256, 8'd200);
        drive_period(200, 256, 8'd200);
        check_section("static");

        drive_period(20, 100, 8'd51);
        drive_period(20, 100, 8'd51);
        do_rise();
        repeat (3) tick();
        u_if.i_PWMIn = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_low");
        exp_q.delete();
        meas_active = 1'b0;
        last_acc = -1000;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        drive_period(40, 100, 8'd102);
        check_section("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
